// File: rtl/uart_rx_word_assembler_if.sv
// ============================================================================
// Module      : uart_rx_word_assembler_if
// Description : Byte-in / word-out bus of the UART receive word assembler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_word_assembler_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int BYTES_PER_WORD = 4
);
  logic                                 rx_done;
  logic [DATA_WIDTH-1:0]                rx_data;
  logic                                 word_valid;
  logic                                 word_ready;
  logic [DATA_WIDTH*BYTES_PER_WORD-1:0] word_data;

  // Producer of bytes and consumer of words.
  modport master (
    output rx_done,
    output rx_data,
    output word_ready,
    input  word_valid,
    input  word_data
  );

  // The assembler itself.
  modport slave (
    input  rx_done,
    input  rx_data,
    input  word_ready,
    output word_valid,
    output word_data
  );
endinterface

`default_nettype wire

// File: rtl/uart_rx_word_assembler.sv
// ============================================================================
// Module      : uart_rx_word_assembler
// Description : Packs received UART bytes little-endian into words, presents
//               them on valid/ready and discards partial words on timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_word_assembler #(
  parameter int DATA_WIDTH     = 8,
  parameter int BYTES_PER_WORD = 4,
  parameter int TIMEOUT_TICKS  = 640
) (
  input  wire logic                    clk,
  input  wire logic                    arst,
  input  wire logic                    tick,
  uart_rx_word_assembler_if.slave      bus,
  output logic                         busy,
  output logic                         overrun,
  output logic                         timeout_err
);

  localparam int c_WORD_W = DATA_WIDTH * BYTES_PER_WORD;
  localparam int c_CNT_W  = $clog2(BYTES_PER_WORD + 1);
  localparam int c_TCK_W  = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;

  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_FULL  = c_CNT_W'(BYTES_PER_WORD);
  localparam logic [c_CNT_W-1:0] c_LAST_LANE = c_CNT_W'(BYTES_PER_WORD - 1);
  localparam logic [c_TCK_W-1:0] c_TICK_LAST = c_TCK_W'(TIMEOUT_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t                r_state;
  logic [c_CNT_W-1:0]    r_byte_cnt;
  logic [c_TCK_W-1:0]    r_tick_cnt;
  logic [c_WORD_W-1:0]   r_word_data;
  logic                  r_word_valid;
  logic                  r_busy;
  logic                  r_overrun;
  logic                  r_timeout_err;

  state_t                w_state_nxt;
  state_t                w_first_state;
  logic [c_CNT_W-1:0]    w_byte_cnt_nxt;
  logic [c_TCK_W-1:0]    w_tick_cnt_nxt;
  logic [c_WORD_W-1:0]   w_word_nxt;
  logic [c_WORD_W-1:0]   w_first_word;
  logic                  w_overrun_nxt;
  logic                  w_timeout_nxt;

  // A single-byte word is complete as soon as its first byte lands.
  assign w_first_state = (BYTES_PER_WORD == 1) ? S_HOLD : S_COLLECT;
  assign w_first_word  = c_WORD_W'(bus.rx_data);

  always_comb begin
    w_state_nxt    = r_state;
    w_byte_cnt_nxt = r_byte_cnt;
    w_tick_cnt_nxt = r_tick_cnt;
    w_word_nxt     = r_word_data;
    w_overrun_nxt  = 1'b0;
    w_timeout_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.rx_done) begin
          w_word_nxt     = w_first_word;
          w_byte_cnt_nxt = c_CNT_ONE;
          w_tick_cnt_nxt = '0;
          w_state_nxt    = w_first_state;
        end
      end

      S_COLLECT: begin
        if (bus.rx_done) begin
          for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (r_byte_cnt == c_CNT_W'(i)) begin
              w_word_nxt[i*DATA_WIDTH +: DATA_WIDTH] = bus.rx_data;
            end
          end
          w_tick_cnt_nxt = '0;
          if (r_byte_cnt == c_LAST_LANE) begin
            w_byte_cnt_nxt = c_CNT_FULL;
            w_state_nxt    = S_HOLD;
          end else begin
            w_byte_cnt_nxt = r_byte_cnt + c_CNT_ONE;
          end
        end else if (tick) begin
          // A byte arriving on the final silent tick takes priority above.
          if (r_tick_cnt == c_TICK_LAST) begin
            w_timeout_nxt  = 1'b1;
            w_byte_cnt_nxt = '0;
            w_tick_cnt_nxt = '0;
            w_word_nxt     = '0;
            w_state_nxt    = S_IDLE;
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + c_TCK_W'(1);
          end
        end
      end

      S_HOLD: begin
        if (bus.word_ready) begin
          if (bus.rx_done) begin
            // Back-to-back: the byte seen at handover starts the next word.
            w_word_nxt     = w_first_word;
            w_byte_cnt_nxt = c_CNT_ONE;
            w_tick_cnt_nxt = '0;
            w_state_nxt    = w_first_state;
          end else begin
            w_byte_cnt_nxt = '0;
            w_state_nxt    = S_IDLE;
          end
        end else if (bus.rx_done) begin
          w_overrun_nxt = 1'b1;
        end
      end

      default: begin
        w_byte_cnt_nxt = '0;
        w_tick_cnt_nxt = '0;
        w_word_nxt     = '0;
        w_state_nxt    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state       <= S_IDLE;
      r_byte_cnt    <= '0;
      r_tick_cnt    <= '0;
      r_word_data   <= '0;
      r_word_valid  <= 1'b0;
      r_busy        <= 1'b0;
      r_overrun     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_byte_cnt    <= w_byte_cnt_nxt;
      r_tick_cnt    <= w_tick_cnt_nxt;
      r_word_data   <= w_word_nxt;
      r_word_valid  <= (w_state_nxt == S_HOLD);
      r_busy        <= (w_state_nxt != S_IDLE);
      r_overrun     <= w_overrun_nxt;
      r_timeout_err <= w_timeout_nxt;
    end
  end

  assign bus.word_valid = r_word_valid;
  assign bus.word_data  = r_word_data;
  assign busy           = r_busy;
  assign overrun        = r_overrun;
  assign timeout_err    = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_word_assembler.sv
// ============================================================================
// Module      : tb_uart_rx_word_assembler
// Description : Scoreboard bench for uart_rx_word_assembler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_word_assembler;

  localparam int c_DW  = 8;
  localparam int c_BPW = 4;
  localparam int c_TO  = 640;

  logic clk = 1'b0;
  logic arst;
  logic tick;
  logic busy;
  logic overrun;
  logic timeout_err;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] sb[$];

  uart_rx_word_assembler_if #(.DATA_WIDTH(c_DW), .BYTES_PER_WORD(c_BPW)) bus ();

  uart_rx_word_assembler #(
    .DATA_WIDTH     (c_DW),
    .BYTES_PER_WORD (c_BPW),
    .TIMEOUT_TICKS  (c_TO)
  ) u_dut (
    .clk         (clk),
    .arst        (arst),
    .tick        (tick),
    .bus         (bus),
    .busy        (busy),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_done = 1'b1;
    bus.rx_data = b;
    step();
    bus.rx_done = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < c_BPW; i++) send_byte(w[i*8 +: 8]);
  endtask

  // Every accepted word is compared against the oldest expected word.
  always @(negedge clk) begin
    if (arst === 1'b0 && bus.word_valid === 1'b1 && bus.word_ready === 1'b1) begin
      check("sb_nonempty", {63'd0, sb.size() != 0}, 64'd1);
      if (sb.size() != 0) check("word", 64'(bus.word_data), 64'(sb.pop_front()));
    end
  end

  initial begin
    arst           = 1'b1;
    tick           = 1'b0;
    bus.rx_done    = 1'b0;
    bus.rx_data    = '0;
    bus.word_ready = 1'b0;
    repeat (2) step();
    check("rst_valid", 64'(bus.word_valid), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_data",  64'(bus.word_data), 64'd0);
    check("rst_ovr",   64'(overrun), 64'd0);
    check("rst_to",    64'(timeout_err), 64'd0);
    arst = 1'b0;
    step();

    // 1: streaming word with ready held high
    bus.word_ready = 1'b1;
    sb.push_back(32'h1234_5678);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34);
    check("t1_valid_early", 64'(bus.word_valid), 64'd0);
    check("t1_busy", 64'(busy), 64'd1);
    send_byte(8'h12);
    check("t1_valid_rise", 64'(bus.word_valid), 64'd1);
    step();
    check("t1_valid_fall", 64'(bus.word_valid), 64'd0);
    check("t1_idle", 64'(busy), 64'd0);

    // 2: consumer stalls for 20 clocks
    bus.word_ready = 1'b0;
    sb.push_back(32'hDDCC_BBAA);
    send_word(32'hDDCC_BBAA);
    for (int i = 0; i < 20; i++) begin
      check("t2_hold_valid", 64'(bus.word_valid), 64'd1);
      check("t2_hold_data", 64'(bus.word_data), 64'hDDCC_BBAA);
      step();
    end
    bus.word_ready = 1'b1;
    step();
    check("t2_valid_fall", 64'(bus.word_valid), 64'd0);

    // 3: inter-byte timeout then clean word
    send_byte(8'hAA); send_byte(8'hBB);
    tick = 1'b1;
    repeat (c_TO - 1) step();
    check("t3_no_to_yet", 64'(timeout_err), 64'd0);
    check("t3_busy_yet", 64'(busy), 64'd1);
    step();
    tick = 1'b0;
    check("t3_to_pulse", 64'(timeout_err), 64'd1);
    check("t3_to_idle", 64'(busy), 64'd0);
    step();
    check("t3_to_clear", 64'(timeout_err), 64'd0);
    sb.push_back(32'h0403_0201);
    send_word(32'h0403_0201);
    step();

    // 4: overrun while holding
    bus.word_ready = 1'b0;
    sb.push_back(32'h4433_2211);
    send_word(32'h4433_2211);
    send_byte(8'h55);
    check("t4_ovr_pulse", 64'(overrun), 64'd1);
    check("t4_word_kept", 64'(bus.word_data), 64'h4433_2211);
    step();
    check("t4_ovr_clear", 64'(overrun), 64'd0);
    bus.word_ready = 1'b1;
    step();
    sb.push_back(32'h0D0C_0B0A);
    send_word(32'h0D0C_0B0A);
    step();

    // 5: byte arrives on the handshake cycle, then on the last silent tick
    bus.word_ready = 1'b0;
    sb.push_back(32'h1413_1211);
    send_word(32'h1413_1211);
    sb.push_back(32'hF0DE_BC9A);
    bus.word_ready = 1'b1;
    send_byte(8'h9A);
    check("t5_busy", 64'(busy), 64'd1);
    check("t5_valid", 64'(bus.word_valid), 64'd0);
    send_byte(8'hBC);
    tick = 1'b1;
    repeat (c_TO - 1) step();
    send_byte(8'hDE);
    tick = 1'b0;
    check("t5_no_to", 64'(timeout_err), 64'd0);
    check("t5_busy2", 64'(busy), 64'd1);
    send_byte(8'hF0);
    step();

    // 6: asynchronous reset mid-word
    send_byte(8'h31); send_byte(8'h32); send_byte(8'h33);
    #2 arst = 1'b1;
    #1;
    check("t6_valid", 64'(bus.word_valid), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_data", 64'(bus.word_data), 64'd0);
    check("t6_ovr", 64'(overrun), 64'd0);
    check("t6_to", 64'(timeout_err), 64'd0);
    @(negedge clk);
    arst = 1'b0;
    step();
    sb.push_back(32'h4443_4241);
    send_word(32'h4443_4241);
    repeat (2) step();
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
